mmio_console: RTL and testbench
===============================

# mmio_console

Memory-mapped console responder on the core data port (`mem_d_*`). Core stores to TXDATA push bytes into a TX FIFO, which drains to the bench over a valid/ready byte stream. Bench-injected bytes enter an RX FIFO that the core pops by loading RXDATA. It sits behind the address decode for the console window as the responder end of the core's data-port initiator.

## Interface
Parameters:
- `TX_DEPTH`, 16: TX FIFO entries; power of 2, at least 2.
- `RX_DEPTH`, 16: RX FIFO entries; power of 2, at least 2.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `mem_d_addr_i` in 32: request address; only `[3:2]` is decoded.
- `mem_d_data_wr_i` in 32: write data.
- `mem_d_rd_i` in 1: read request.
- `mem_d_wr_i` in 4: byte write enables.
- `mem_d_cacheable_i`, `mem_d_invalidate_i`, `mem_d_writeback_i`, `mem_d_flush_i` in 1 each: accepted and acked; no other effect.
- `mem_d_req_tag_i` in 11: request tag.
- `mem_d_accept_o` out 1: request accepted this cycle.
- `mem_d_ack_o` out 1: response valid.
- `mem_d_error_o` out 1: response error.
- `mem_d_data_rd_o` out 32: read response data.
- `mem_d_resp_tag_o` out 11: echoed request tag.
- `tx_valid_o` out 1, `tx_data_o` out 8, `tx_ready_i` in 1: TX byte stream.
- `rx_valid_i` in 1, `rx_data_i` in 8, `rx_ready_o` out 1: RX byte stream.
- `irq_o` out 1: RX interrupt (see Configuration).

## Operation
- A request exists when `mem_d_rd_i`, `mem_d_wr_i != 0`, or any of flush/invalidate/writeback is high. It transfers when the request and `mem_d_accept_o` are both high.
- `mem_d_accept_o` = !(write to TXDATA && tx_full). All other requests are always accepted.
- Register map, by `addr[3:2]`:
  - 0 TXDATA (W): if `wr[0]`, push `data_wr[7:0]`. Lanes 1–3 are ignored. Reads return 0.
  - 1 RXDATA (R): returns `{23'b0, rx_not_empty, rx_head[7:0]}`. Pops only if not empty. Reading while empty returns 0 and has no side effect. Writes are ignored.
  - 2 STATUS (R): bit0 rx_not_empty, bit1 tx_full, bit2 tx_empty, bits[15:8] rx_count (saturates at 255). Writes are ignored.
  - 3 CTRL (RW): bit0 rx_irq_en, when compiled in; otherwise reads 0.
- A request with both rd and wr set performs the write and returns read data.
- No address produces an error. `mem_d_error_o` is always 0.
- TX stream: `tx_valid_o` = !tx_empty and `tx_data_o` = TX head. The FIFO pops when `tx_valid_o & tx_ready_i`.
- RX stream: `rx_ready_o` = !rx_full and the FIFO pushes on `rx_valid_i & rx_ready_o`. Bytes offered while full are held by the source, not dropped.
- Simultaneous push and pop on the same FIFO in one cycle are both honoured; count is unchanged. The core pop of RXDATA and a bench RX push in the same cycle are both honoured.

## Timing
- Fixed 1-cycle response: an accept in cycle N gives `mem_d_ack_o`=1 in N+1, with data and tag registered at N.
- Back-to-back accepts produce back-to-back acks. No internal response queue is kept.
- Read data reflects state before cycle N's updates (read-before-write).
- FIFO writes become visible on the FIFO outputs one cycle after the push.
- Reset values:
  - `mem_d_ack_o`, `mem_d_error_o`, `tx_valid_o`, `irq_o` = 0.
  - `mem_d_data_rd_o`, `mem_d_resp_tag_o`, `tx_data_o` = 0.
  - `mem_d_accept_o` = 1, `rx_ready_o` = 1.
  - Both FIFOs empty; CTRL = 0.
- Reset mid-operation discards FIFO contents and any pending ack in the next cycle.

## Configuration
- `MMIO_CONSOLE_IRQ_EN` defined:
  - CTRL bit0 is implemented.
  - `irq_o` is registered as rx_irq_en & rx_not_empty, updated each cycle.
- `MMIO_CONSOLE_IRQ_EN` undefined:
  - CTRL reads 0 and writes are ignored.
  - `irq_o` is tied to 0.

## Structure
- Package `mmio_console_pkg`:
  - register offsets.
  - STATUS bit positions.
  - `CTRL_RX_IRQ_EN` bit index.
- Sub-module `mmio_console_fifo` (width and depth parameters; synchronous; count, full and empty outputs) is instantiated twice, once for TX and once for RX.

## Test plan
- Three stores to offset 0x0 (0x48, 0x69, 0x0A) with `tx_ready_i`=1 -> acks in the following cycles; `tx_data_o` emits 0x48, 0x69, 0x0A in order.
- `tx_ready_i`=0 and 17 TXDATA stores -> 16 accepted. The 17th sees `mem_d_accept_o`=0 until `tx_ready_i` rises, then is accepted the cycle after the pop.
- Bench pushes 0x41 then core loads 0x4 -> ack data 0x141. A second load returns 0x000.
- 16 RX bytes with no core reads -> `rx_ready_o`=0 and STATUS reads 0x1001. A 17th byte is held until one RXDATA pop.
- Back-to-back requests with tags 5 then 6 -> acks in consecutive cycles with `mem_d_resp_tag_o` 5 then 6, and `mem_d_error_o`=0.
- IRQ_EN build, store 1 to 0xC, inject one RX byte -> `irq_o`=1. After the RXDATA pop, `irq_o`=0. Asserting `rst_i` mid-stream -> `tx_valid_o`=0 and STATUS=0x0004 on the next read.

Source files
------------

// File: rtl/mmio_console_pkg.sv
// Shared definitions for the mmio_console responder: register offsets, STATUS/CTRL bit positions.
package mmio_console_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    localparam int STATUS_RX_NOT_EMPTY = 0;
    localparam int STATUS_TX_FULL      = 1;
    localparam int STATUS_TX_EMPTY     = 2;
    localparam int STATUS_RX_COUNT_LSB = 8;

    localparam int CTRL_RX_IRQ_EN = 0;

    // Clamp a count into the 8-bit STATUS field.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// Synchronous FIFO with count/full/empty; head data reads as zero while empty.
module mmio_console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer and occupancy tracking; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console responder: TXDATA/RXDATA/STATUS/CTRL over the core data port.
// Optional RX interrupt and CTRL register compiled in with MMIO_CONSOLE_IRQ_EN.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    input  logic [10:0] mem_d_req_tag_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    reg_sel_e    sel_s;
    logic        req_s, wr_any_s, accept_s, xfer_s;
    logic        tx_push_s, tx_full_s, tx_empty_s;
    logic        rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]  rx_head_s;
    logic [TXCW-1:0] tx_count_s;
    logic [RXCW-1:0] rx_count_s;
    logic        ctrl_irq_en_s;
    logic [31:0] rdata_s;

    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [10:0] tag_q, tag_d;

    logic unused_s;
    assign unused_s = ^{mem_d_addr_i[31:4], mem_d_addr_i[1:0], mem_d_data_wr_i[31:8],
                        mem_d_cacheable_i, tx_count_s};

    assign sel_s    = reg_sel_e'(mem_d_addr_i[3:2]);
    assign wr_any_s = |mem_d_wr_i;
    assign req_s    = mem_d_rd_i | wr_any_s | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
    // Only a TXDATA write can stall, and only while the TX FIFO has no room.
    assign accept_s = ~(wr_any_s & (sel_s == REG_TXDATA) & tx_full_s);
    assign xfer_s   = req_s & accept_s;

    assign tx_push_s = xfer_s & (sel_s == REG_TXDATA) & mem_d_wr_i[0];
    assign rx_pop_s  = xfer_s & mem_d_rd_i & (sel_s == REG_RXDATA) & ~rx_empty_s;

    mmio_console_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push_s),
        .data_i  (mem_d_data_wr_i[7:0]),
        .pop_i   (tx_valid_o & tx_ready_i),
        .data_o  (tx_data_o),
        .count_o (tx_count_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s)
    );

    mmio_console_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_valid_i & rx_ready_o),
        .data_i  (rx_data_i),
        .pop_i   (rx_pop_s),
        .data_o  (rx_head_s),
        .count_o (rx_count_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s)
    );

    // Read mux over pre-update state.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            REG_TXDATA: rdata_s = 32'd0;
            REG_RXDATA: rdata_s = {23'd0, ~rx_empty_s, rx_head_s};
            REG_STATUS: begin
                rdata_s[STATUS_RX_NOT_EMPTY]         = ~rx_empty_s;
                rdata_s[STATUS_TX_FULL]              = tx_full_s;
                rdata_s[STATUS_TX_EMPTY]             = tx_empty_s;
                rdata_s[STATUS_RX_COUNT_LSB +: 8]    = sat8(32'(rx_count_s));
            end
            REG_CTRL:   rdata_s[CTRL_RX_IRQ_EN] = ctrl_irq_en_s;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Response next-state: data and tag captured on the accepting cycle.
    always_comb begin
        ack_d   = xfer_s;
        rdata_d = rdata_q;
        tag_d   = tag_q;
        if (xfer_s) begin
            rdata_d = mem_d_rd_i ? rdata_s : 32'd0;
            tag_d   = mem_d_req_tag_i;
        end else begin
            rdata_d = rdata_q;
            tag_d   = tag_q;
        end
    end

    // Response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            tag_q   <= 11'd0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            tag_q   <= tag_d;
        end
    end

`ifdef MMIO_CONSOLE_IRQ_EN
    logic ctrl_q, ctrl_d;
    logic irq_q;

    // CTRL write decode.
    always_comb begin
        ctrl_d = ctrl_q;
        if (xfer_s && (sel_s == REG_CTRL) && mem_d_wr_i[0]) begin
            ctrl_d = mem_d_data_wr_i[CTRL_RX_IRQ_EN];
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // CTRL and interrupt registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= ctrl_q & ~rx_empty_s;
        end
    end

    assign ctrl_irq_en_s = ctrl_q;
    assign irq_o         = irq_q;
`else
    assign ctrl_irq_en_s = 1'b0;
    assign irq_o         = 1'b0;
`endif

    assign mem_d_accept_o   = accept_s;
    assign mem_d_ack_o      = ack_q;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_data_rd_o  = rdata_q;
    assign mem_d_resp_tag_o = tag_q;
    assign tx_valid_o       = ~tx_empty_s;
    assign rx_ready_o       = ~rx_full_s;

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: vector table plus scoreboarded acks and TX bytes.
module tb_mmio_console;

`ifdef MMIO_CONSOLE_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        rd, fl, cach, inv, wb;
    logic [3:0]  wr;
    logic [10:0] tag;
    logic        accept, ack, err;
    logic [31:0] rdata;
    logic [10:0] rtag;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [7:0]  tx_data, rx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mmio_console #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_d_addr_i       (addr),
        .mem_d_data_wr_i    (wdata),
        .mem_d_rd_i         (rd),
        .mem_d_wr_i         (wr),
        .mem_d_cacheable_i  (cach),
        .mem_d_invalidate_i (inv),
        .mem_d_writeback_i  (wb),
        .mem_d_flush_i      (fl),
        .mem_d_req_tag_i    (tag),
        .mem_d_accept_o     (accept),
        .mem_d_ack_o        (ack),
        .mem_d_error_o      (err),
        .mem_d_data_rd_o    (rdata),
        .mem_d_resp_tag_o   (rtag),
        .tx_valid_o         (tx_valid),
        .tx_data_o          (tx_data),
        .tx_ready_i         (tx_ready),
        .rx_valid_i         (rx_valid),
        .rx_data_i          (rx_data),
        .rx_ready_o         (rx_ready),
        .irq_o              (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic [3:0]  wr;
        logic        fl;
        logic [10:0] tag;
        logic        inj;
        logic [7:0]  inj_byte;
        logic        txp;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [10:0] tag;
        int          cyc;
    } exp_t;

    exp_t       ack_q[$];
    logic [7:0] tx_q[$];
    vec_t       tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every ack and every TX handshake must match the head of its queue.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] b;
        if (!rst) begin
            if (ack) begin
                chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
                if (ack_q.size() != 0) begin
                    e = ack_q.pop_front();
                    chk("ack_data", rdata, e.data);
                    chk("ack_tag", {21'd0, rtag}, {21'd0, e.tag});
                    chk("ack_latency", cyc, e.cyc + 1);
                    chk("ack_error", {31'd0, err}, 32'd0);
                end
            end
            if (tx_valid && tx_ready) begin
                chk("tx_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) begin
                    b = tx_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, b});
                end
            end
        end
    end

    task automatic idle();
        addr = 32'd0; wdata = 32'd0; rd = 1'b0; wr = 4'd0; fl = 1'b0; tag = 11'd0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic r,
                         input logic [3:0] w, input logic f, input logic [10:0] t,
                         input logic [31:0] exp, output int waited);
        exp_t e;
        int   n;
        addr = a; wdata = d; rd = r; wr = w; fl = f; tag = t;
        n = 0;
        @(negedge clk);
        while (!accept && n < 100) begin
            n++;
            @(negedge clk);
        end
        waited = n;
        chk("accept_in_time", {31'd0, accept}, 32'd1);
        if (accept) begin
            e.data = exp; e.tag = t; e.cyc = cyc;
            ack_q.push_back(e);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rx_send(input logic [7:0] b);
        int n;
        rx_valid = 1'b1; rx_data = b;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rx_ready_in_time", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ack_q.delete();
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1; cach = 1'b0; inv = 1'b0; wb = 1'b0;
        idle();
        rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;

        // Main vector table: addr, wdata, rd, wr, flush, tag, inj, inj_byte, txp, expected read data.
        tbl[0]  = '{32'h0, 32'h48, 1'b0, 4'h1, 1'b0, 11'd1, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[1]  = '{32'h0, 32'h69, 1'b0, 4'h1, 1'b0, 11'd2, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[2]  = '{32'h0, 32'h0A, 1'b0, 4'h1, 1'b0, 11'd3, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[3]  = '{32'h4, 32'h0,  1'b1, 4'h0, 1'b0, 11'd4, 1'b1, 8'h41, 1'b0, 32'h141};
        tbl[4]  = '{32'h4, 32'h0,  1'b1, 4'h0, 1'b0, 11'd7, 1'b0, 8'h00, 1'b0, 32'h0};
        tbl[5]  = '{32'h8, 32'h0,  1'b1, 4'h0, 1'b0, 11'd5, 1'b0, 8'h00, 1'b0, 32'h4};
        tbl[6]  = '{32'hC, 32'h0,  1'b1, 4'h0, 1'b0, 11'd6, 1'b0, 8'h00, 1'b0, 32'h0};
        tbl[7]  = '{32'hC, 32'h1,  1'b1, 4'hF, 1'b0, 11'd8, 1'b0, 8'h00, 1'b0, 32'h0};
        tbl[8]  = '{32'hC, 32'h0,  1'b1, 4'h0, 1'b0, 11'd9, 1'b0, 8'h00, 1'b0, {31'd0, IRQ_BUILD}};
        tbl[9]  = '{32'hC, 32'h0,  1'b0, 4'h1, 1'b0, 11'd10, 1'b0, 8'h00, 1'b0, 32'h0};
        tbl[10] = '{32'h0, 32'hFFFFFF77, 1'b0, 4'hE, 1'b0, 11'd11, 1'b0, 8'h00, 1'b0, 32'h0};
        tbl[11] = '{32'h4, 32'h0,  1'b0, 4'h0, 1'b1, 11'd12, 1'b1, 8'h42, 1'b0, 32'h0};
        tbl[12] = '{32'h4, 32'h0,  1'b1, 4'h0, 1'b0, 11'd13, 1'b0, 8'h00, 1'b0, 32'h142};
        tbl[13] = '{32'h0, 32'h5A, 1'b1, 4'h1, 1'b0, 11'd14, 1'b0, 8'h00, 1'b1, 32'h0};
        tbl[14] = '{32'hFFFFFFF8, 32'h0, 1'b1, 4'h0, 1'b0, 11'h7FF, 1'b0, 8'h00, 1'b0, 32'h0};

        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rtag", {21'd0, rtag}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_accept", {31'd0, accept}, 32'd1);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].inj) rx_send(tbl[i].inj_byte);
            if (tbl[i].txp) tx_q.push_back(tbl[i].wdata[7:0]);
            issue(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].fl, tbl[i].tag, tbl[i].exp, w);
        end
        wait_cycles(5);
        chk("tx_drained", tx_q.size(), 32'd0);

        // TX back-pressure: 16 stores fit, the 17th waits for a pop.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'(8'h10 + i));
            issue(32'h0, 32'(8'h10 + i), 1'b0, 4'h1, 1'b0, 11'(20 + i), 32'h0, w);
            chk("tx_fill_wait", w, 32'd0);
        end
        addr = 32'h0; wdata = 32'h20; wr = 4'h1; tag = 11'd40;
        repeat (3) begin
            @(negedge clk);
            chk("tx_full_accept", {31'd0, accept}, 32'd0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        tx_q.push_back(8'h20);
        issue(32'h0, 32'h20, 1'b0, 4'h1, 1'b0, 11'd40, 32'h0, w);
        chk("tx_full_wait", w, 32'd1);
        wait_cycles(25);
        chk("tx_full_drained", tx_q.size(), 32'd0);

        // RX fill: 16 bytes stop the stream, a 17th is held until one pop.
        do_reset();
        tx_ready = 1'b0;
        tx_q.push_back(8'h55);
        issue(32'h0, 32'h55, 1'b0, 4'h1, 1'b0, 11'd50, 32'h0, w);
        for (int i = 0; i < 16; i++) rx_send(8'(8'h30 + i));
        @(negedge clk);
        chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        @(posedge clk); #1;
        issue(32'h8, 32'h0, 1'b1, 4'h0, 1'b0, 11'd51, 32'h1001, w);
        rx_valid = 1'b1; rx_data = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("rx_held", {31'd0, rx_ready}, 32'd0);
        end
        @(posedge clk); #1;
        issue(32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 11'd52, 32'h130, w);
        rx_valid = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_pop", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int i = 1; i < 16; i++)
            issue(32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 11'(60 + i), 32'h130 + 32'(i), w);
        issue(32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 11'd80, 32'h199, w);
        issue(32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 11'd81, 32'h0, w);
        issue(32'h8, 32'h0, 1'b1, 4'h0, 1'b0, 11'd82, 32'h0, w);

        // Interrupt: enable, inject, pop.
        do_reset();
        tx_ready = 1'b1;
        issue(32'hC, 32'h1, 1'b0, 4'h1, 1'b0, 11'd90, 32'h0, w);
        @(negedge clk);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rx_send(8'h07);
        wait_cycles(2);
        @(negedge clk);
        chk("irq_set", {31'd0, irq}, {31'd0, IRQ_BUILD});
        @(posedge clk); #1;
        issue(32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 11'd91, 32'h107, w);
        wait_cycles(2);
        @(negedge clk);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-stream with a request in flight.
        tx_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tx_q.push_back(8'(i));
            issue(32'h0, 32'(i), 1'b0, 4'h1, 1'b0, 11'(100 + i), 32'h0, w);
        end
        @(negedge clk);
        chk("mid_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("mid_tx_data", {24'd0, tx_data}, 32'h1);
        @(posedge clk); #1;
        addr = 32'h0; wdata = 32'h4; wr = 4'h1; tag = 11'd110;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        tx_q.delete();
        @(negedge clk);
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        issue(32'h8, 32'h0, 1'b1, 4'h0, 1'b0, 11'd111, 32'h4, w);
        issue(32'hC, 32'h0, 1'b1, 4'h0, 1'b0, 11'd112, 32'h0, w);

        wait_cycles(3);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
